noc_msg_arbiter: RTL
====================

# noc_msg_arbiter

Message-atomic round-robin arbiter that shares one NoC output channel between `NUM_SRCS` requesters, such as several engine pipes driving one NoC0 port toward a sink. Each requester offers whole NoC messages: one `noc_hdr_flit` header followed by `msg_len` payload flits. Once a header is granted, the arbiter locks onto that source until the last payload flit is accepted, so messages never interleave. The data path is a combinational mux with zero added latency.

## Interface
- `NUM_SRCS`, 4: number of requesters; legal range 2..16.
- `SRC_W`, `$clog2(NUM_SRCS)`: width of the source index. Derived; do not override.
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `src_arb_val`, in, `[NUM_SRCS-1:0]`: per-source flit valid.
- `src_arb_data`, in, `[NUM_SRCS-1:0][NOC_DATA_WIDTH-1:0]`: per-source flit.
- `arb_src_rdy`, out, `[NUM_SRCS-1:0]`: per-source ready; at most one bit set.
- `arb_dst_val`, out, 1: output flit valid.
- `arb_dst_data`, out, `NOC_DATA_WIDTH`: output flit.
- `dst_arb_rdy`, in, 1: downstream ready.
- `arb_gnt_idx`, out, `SRC_W`: current or last granted source.
- `arb_busy`, out, 1: high in `HDR_HOLD` and `PAYLOAD`.

## Operation
- Handshake: a flit transfers when `val` and `rdy` are both high on a rising `clk` edge. Sources hold `val` and data stable until accepted. The arbiter never drops `arb_dst_val` before acceptance.
- Round-robin pointer `rr_ptr_reg` (`SRC_W` bits). The winner is the first source with `val` high, searching from `rr_ptr_reg` upward and wrapping modulo `NUM_SRCS`.
- States:
  - `ARB`
    - `arb_dst_val` = OR of `src_arb_val`; data = winner's flit; `arb_src_rdy[winner]` = `dst_arb_rdy`.
    - Header accepted, `msg_len==0`: stay in `ARB`; `rr_ptr_reg` ← winner+1 (wraps).
    - Header accepted, `msg_len>0`: `gnt_reg` ← winner; `flits_sent_reg` ← 0; go to `PAYLOAD`.
    - Header offered but not accepted: `gnt_reg` ← winner; go to `HDR_HOLD`. This freezes the grant so the offered flit stays stable.
    - No source valid: outputs idle; no state change.
  - `HDR_HOLD`: present source `gnt_reg`; `msg_len` is taken from its header. On accept, branch exactly as in `ARB` (to `ARB` or `PAYLOAD`).
  - `PAYLOAD`
    - `arb_dst_val` = `src_arb_val[gnt_reg]`; `arb_src_rdy[gnt_reg]` = `dst_arb_rdy`; all other ready bits 0.
    - Each accepted flit increments `flits_sent_reg`.
    - When the accepted flit makes `flits_sent_reg+1 == locked_len_reg`: go to `ARB`; `rr_ptr_reg` ← `gnt_reg`+1.
- `locked_len_reg` (`MSG_LENGTH_WIDTH` bits) captures `msg_len` on header accept. The counter has the same width. `msg_len` = max (all ones) is legal and must not wrap early.
- Other sources' `val` has no effect while locked.
- `arb_gnt_idx` = winner in `ARB`, `gnt_reg` otherwise.

## Timing
- Zero-cycle latency, source to output, in every state. No flit is buffered.
- One header arbitration per cycle. A 0-payload message from each of N sources completes in N cycles when `dst_arb_rdy` is held high.
- Back-to-back messages: the cycle after the last payload flit is accepted is an `ARB` cycle, so the next header may transfer with no bubble.
- Reset (asynchronous assert, synchronous-safe deassert), effective immediately, including mid-message:
  - `state_reg` = `ARB`, `rr_ptr_reg` = 0, `gnt_reg` = 0, `flits_sent_reg` = 0, `locked_len_reg` = 0.
  - All outputs read 0 while `rst_n` is low.
  - A message in flight is abandoned. Sources are responsible for their own reset.
- Simultaneous header requests: exactly one source is granted; the rest see `rdy`=0.

## Structure
- Uses `noc_defs.vh` and `noc_struct_defs.vh` for `NOC_DATA_WIDTH`, `MSG_LENGTH_WIDTH` and `noc_hdr_flit`. The `msg_len` field is extracted through the struct, never by bit slicing.
- The state enum `noc_arb_state_e` {`ARB`, `HDR_HOLD`, `PAYLOAD`} goes in a shared package `noc_arb_pkg`, for reuse by other arbiters.
- One sub-module: `rr_pick` (combinational). Inputs: request vector and `rr_ptr_reg`. Outputs: winner index and `any_req`.

## Test plan
1. Basic message, `NUM_SRCS`=4, `dst_arb_rdy`=1:
   - Stimulus: src2 alone sends a header with `msg_len`=3 and three payload flits.
   - Required: 4 consecutive flits out, unchanged; `arb_busy` high for 3 cycles; `rr_ptr_reg`=3 afterward.
2. Fairness:
   - Stimulus: all 4 sources continuously offer `msg_len`=1 messages.
   - Required: grant order 0,1,2,3,0…; each message occupies 2 output cycles; no interleaving.
3. Header backpressure:
   - Stimulus: src1 and src3 valid, `rdy`=0 for 5 cycles; src0 raises `val` during the stall.
   - Required: output stays src1's header and `arb_gnt_idx`=1 throughout; src1 is accepted when `rdy` rises.
4. Payload stalls:
   - Stimulus: `msg_len`=2; source drops `val` mid-message while others request.
   - Required: output `val`=0 during the gap; no other source is granted until flit 2 is accepted.
5. Zero-length and max-length messages:
   - `msg_len`=0: stays in `ARB`; pointer advances by 1.
   - `msg_len`=all-ones: exactly that many payload flits; no early release.
6. Mid-message reset:
   - Stimulus: `rst_n` pulled low after payload flit 1 of 3.
   - Required: all outputs 0 immediately; after release, the next grant comes from src0.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared NoC arbitration types.
//   NOC_DATA_WIDTH / MSG_LENGTH_WIDTH : flit and length-field widths
//   noc_hdr_flit                      : header flit layout (msg_len field)
//   noc_arb_state_e                   : arbiter states, reused by sibling arbiters
//   hdr_msg_len()                     : msg_len extraction through the header struct
package noc_arb_pkg;

    localparam int unsigned NOC_DATA_WIDTH   = 64;
    localparam int unsigned MSG_LENGTH_WIDTH = 8;

    // Header flit, MSB first; fixed fields sum to NOC_DATA_WIDTH.
    typedef struct packed {
        logic [13:0]                 dst_chipid;
        logic [7:0]                  dst_x;
        logic [7:0]                  dst_y;
        logic [3:0]                  dst_fbits;
        logic [MSG_LENGTH_WIDTH-1:0] msg_len;
        logic [7:0]                  msg_type;
        logic [7:0]                  mshrid;
        logic [5:0]                  options;
    } noc_hdr_flit;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        HDR_HOLD = 2'd1,
        PAYLOAD  = 2'd2
    } noc_arb_state_e;

    // Payload length of a header flit.
    function automatic logic [MSG_LENGTH_WIDTH-1:0] hdr_msg_len(
        input logic [NOC_DATA_WIDTH-1:0] flit
    );
        noc_hdr_flit hdr;
        hdr = noc_hdr_flit'(flit);
        return hdr.msg_len;
    endfunction

endpackage

// File: rtl/noc_msg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index
//   winner  : first requester at or after ptr (wrapping); ptr when none
//   any_req : at least one request present
module rr_pick #(
    parameter int unsigned NUM_SRCS = 4,
    parameter int unsigned SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic [NUM_SRCS-1:0] req,
    input  logic [SRC_W-1:0]    ptr,
    output logic [SRC_W-1:0]    winner,
    output logic                any_req
);

    // (base + off) mod NUM_SRCS, valid for base < NUM_SRCS and off < NUM_SRCS.
    function automatic logic [SRC_W-1:0] wrap_add(
        input logic [SRC_W-1:0] base,
        input int unsigned      off
    );
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_SRCS) begin
            sum = sum - NUM_SRCS;
        end
        return SRC_W'(sum);
    endfunction

    // Scan farthest-from-ptr first so the nearest requester is written last.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NUM_SRCS; i++) begin
            if (req[wrap_add(ptr, NUM_SRCS - 1 - i)]) begin
                winner  = wrap_add(ptr, NUM_SRCS - 1 - i);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_msg_arbiter.sv
// noc_msg_arbiter: message-atomic round-robin arbiter for one NoC output.
//   clk, rst_n    : clock, async active-low reset
//   src_arb_val   : per-source flit valid
//   src_arb_data  : per-source flit
//   arb_src_rdy   : per-source ready (one-hot or zero)
//   arb_dst_val   : output flit valid
//   arb_dst_data  : output flit (zero-latency mux)
//   dst_arb_rdy   : downstream ready
//   arb_gnt_idx   : current winner in ARB, locked source otherwise
//   arb_busy      : locked onto a source (HDR_HOLD or PAYLOAD)
module noc_msg_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_SRCS = 4,
    parameter int unsigned SRC_W    = $clog2(NUM_SRCS)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_SRCS-1:0]                     src_arb_val,
    input  logic [NUM_SRCS-1:0][NOC_DATA_WIDTH-1:0] src_arb_data,
    output logic [NUM_SRCS-1:0]                     arb_src_rdy,
    output logic                                    arb_dst_val,
    output logic [NOC_DATA_WIDTH-1:0]               arb_dst_data,
    input  logic                                    dst_arb_rdy,
    output logic [SRC_W-1:0]                        arb_gnt_idx,
    output logic                                    arb_busy
);

    localparam int unsigned LEN_W = MSG_LENGTH_WIDTH;

    noc_arb_state_e      state_q, state_d;
    logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]    gnt_q, gnt_d;
    logic [LEN_W-1:0]    flits_sent_q, flits_sent_d;
    logic [LEN_W-1:0]    locked_len_q, locked_len_d;

    logic [SRC_W-1:0]    win_c;
    logic                any_req_c;
    logic [SRC_W-1:0]    sel_c;
    logic [LEN_W-1:0]    hdr_len_c;
    logic                dst_val_c;
    logic [NUM_SRCS-1:0] src_rdy_c;
    logic                accept_c;

    function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
        return (idx == SRC_W'(NUM_SRCS - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .NUM_SRCS (NUM_SRCS),
        .SRC_W    (SRC_W)
    ) u_rr_pick (
        .req     (src_arb_val),
        .ptr     (rr_ptr_q),
        .winner  (win_c),
        .any_req (any_req_c)
    );

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            flits_sent_q <= '0;
            locked_len_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            flits_sent_q <= flits_sent_d;
            locked_len_q <= locked_len_d;
        end
    end

    // Source selection, handshake and next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        flits_sent_d = flits_sent_q;
        locked_len_d = locked_len_q;
        src_rdy_c    = '0;

        sel_c     = (state_q == ARB) ? win_c : gnt_q;
        hdr_len_c = hdr_msg_len(src_arb_data[sel_c]);

        if (state_q == ARB) begin
            dst_val_c = any_req_c;
            if (any_req_c) begin
                src_rdy_c[sel_c] = dst_arb_rdy;
            end
        end else begin
            dst_val_c        = src_arb_val[gnt_q];
            src_rdy_c[gnt_q] = dst_arb_rdy;
        end

        accept_c = dst_val_c & dst_arb_rdy;

        case (state_q)
            ARB, HDR_HOLD: begin
                if (accept_c) begin
                    if (hdr_len_c == '0) begin
                        state_d  = ARB;
                        rr_ptr_d = next_idx(sel_c);
                    end else begin
                        state_d      = PAYLOAD;
                        gnt_d        = sel_c;
                        flits_sent_d = '0;
                        locked_len_d = hdr_len_c;
                    end
                end else if (state_q == ARB && any_req_c) begin
                    // Freeze the grant so the offered header stays stable.
                    state_d = HDR_HOLD;
                    gnt_d   = win_c;
                end
            end
            PAYLOAD: begin
                if (accept_c) begin
                    flits_sent_d = flits_sent_q + 1'b1;
                    // flits_sent_q < locked_len_q here, so +1 cannot wrap.
                    if (LEN_W'(flits_sent_q + 1'b1) == locked_len_q) begin
                        state_d  = ARB;
                        rr_ptr_d = next_idx(gnt_q);
                    end
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Outputs are forced to zero for as long as reset is asserted.
    assign arb_dst_val  = rst_n & dst_val_c;
    assign arb_src_rdy  = rst_n ? src_rdy_c : '0;
    assign arb_dst_data = (rst_n && dst_val_c) ? src_arb_data[sel_c] : '0;
    assign arb_gnt_idx  = rst_n ? sel_c : '0;
    assign arb_busy     = rst_n & (state_q != ARB);

endmodule
